// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes, FSM state encoding and frame-length constants shared by the SPI RAM master.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int CMD_BITS = 10;
    localparam int RD_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TURN  = 3'd3,
        READ  = 3'd4,
        GAP   = 3'd5
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides clk by 2*CLK_DIV into a mode-0 sclk, with one-cycle strobes marking the
// clk edge on which sclk rises or falls. Held low and phase-reset whenever en is low.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div_r;
    logic          sclk_r;
    logic          edge_s;

    // Half-period terminal count; strobes are valid for the edge that toggles sclk.
    always_comb begin
        edge_s   = en && (div_r == DW'(CLK_DIV - 1));
        rise_stb = edge_s && !sclk_r;
        fall_stb = edge_s && sclk_r;
    end

    // Divider counter and sclk register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= {DW{1'b0}};
            sclk_r <= 1'b0;
        end else if (!en) begin
            div_r  <= {DW{1'b0}};
            sclk_r <= 1'b0;
        end else if (edge_s) begin
            div_r  <= {DW{1'b0}};
            sclk_r <= ~sclk_r;
        end else begin
            div_r  <= div_r + DW'(1);
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_ram_master.sv
// spi_ram_master: SPI mode-0 master issuing ADDR_SIZE+2 bit RAM command frames and returning read bytes.
// Define SPI_RAM_MASTER_STATUS_EN to add the frame_cnt completed-frame counter output.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_SIZE+1:0]   cmd_data,
    output logic                   rsp_valid,
    output logic [ADDR_SIZE-1:0]   rsp_data,
    output logic                   busy,
    output logic                   sclk,
    output logic                   ss_n,
    output logic                   mosi,
    input  logic                   miso
`ifdef SPI_RAM_MASTER_STATUS_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int FW = ADDR_SIZE + 2;
    localparam int BW = $clog2(FW + 1);
    localparam int WW = $clog2(2 * CLK_DIV + 1);

    state_t                 state_r;
    state_t                 next_s;
    logic [FW-1:0]          tx_r;
    logic [1:0]             op_r;
    logic [ADDR_SIZE-1:0]   rx_r;
    logic [ADDR_SIZE-1:0]   rsp_data_r;
    logic [BW-1:0]          bit_r;
    logic [WW-1:0]          wait_r;
    logic                   ss_n_r;
    logic                   mosi_r;
    logic                   rsp_valid_r;
    logic                   ss_n_nx_s;
    logic                   rsp_valid_nx_s;
    logic                   gen_en_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   accept_s;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (gen_en_s),
        .sclk     (sclk),
        .rise_stb (rise_s),
        .fall_stb (fall_s)
    );

    assign accept_s  = cmd_valid && (state_r == IDLE);
    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; GAP is one cycle short so that, counting the IDLE accept cycle, ss_n stays high 2*CLK_DIV cycles.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:  if (accept_s) next_s = SETUP; else next_s = IDLE;
            SETUP: if (wait_r == WW'(CLK_DIV - 1)) next_s = SHIFT; else next_s = SETUP;
            SHIFT: begin
                if (fall_s && (bit_r == BW'(FW - 1))) begin
                    if (op_r == OP_RD_DATA) next_s = TURN; else next_s = GAP;
                end else begin
                    next_s = SHIFT;
                end
            end
            TURN:  if (fall_s) next_s = READ; else next_s = TURN;
            READ:  if (fall_s && (bit_r == BW'(ADDR_SIZE - 1))) next_s = GAP; else next_s = READ;
            GAP:   if (wait_r == WW'(2 * CLK_DIV - 2)) next_s = IDLE; else next_s = GAP;
            default: next_s = IDLE;
        endcase
    end

    // Output decode, evaluated one cycle ahead so the registered outputs line up with the state.
    always_comb begin
        ss_n_nx_s      = 1'b1;
        rsp_valid_nx_s = 1'b0;
        gen_en_s       = 1'b0;
        case (next_s)
            IDLE:    ss_n_nx_s = 1'b1;
            GAP:     ss_n_nx_s = 1'b1;
            default: ss_n_nx_s = 1'b0;
        endcase
        case (state_r)
            SHIFT, TURN, READ: gen_en_s = 1'b1;
            default:           gen_en_s = 1'b0;
        endcase
        if ((state_r == READ) && (next_s == GAP)) begin
            rsp_valid_nx_s = 1'b1;
        end else begin
            rsp_valid_nx_s = 1'b0;
        end
    end

    // Shift registers, bit/wait counters and registered SPI outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r        <= {FW{1'b0}};
            op_r        <= 2'b00;
            rx_r        <= {ADDR_SIZE{1'b0}};
            rsp_data_r  <= {ADDR_SIZE{1'b0}};
            bit_r       <= {BW{1'b0}};
            wait_r      <= {WW{1'b0}};
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            ss_n_r      <= ss_n_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            if ((next_s != state_r) || (state_r == IDLE)) begin
                wait_r <= {WW{1'b0}};
            end else begin
                wait_r <= wait_r + WW'(1);
            end
            if (accept_s) begin
                mosi_r <= cmd_data[FW-1];
                tx_r   <= {cmd_data[FW-2:0], 1'b0};
                op_r   <= cmd_data[FW-1 -: 2];
                bit_r  <= {BW{1'b0}};
            end else if (fall_s) begin
                bit_r <= (next_s != state_r) ? {BW{1'b0}} : bit_r + BW'(1);
                if ((state_r == SHIFT) && (next_s == SHIFT)) begin
                    mosi_r <= tx_r[FW-1];
                    tx_r   <= {tx_r[FW-2:0], 1'b0};
                end else begin
                    mosi_r <= 1'b0;
                end
            end else if (rise_s && (state_r == READ)) begin
                rx_r <= {rx_r[ADDR_SIZE-2:0], miso};
            end else begin
                rx_r <= rx_r;
            end
            if (rsp_valid_nx_s) begin
                rsp_data_r <= rx_r;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign ss_n      = ss_n_r;
    assign mosi      = mosi_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

`ifdef SPI_RAM_MASTER_STATUS_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter, bumped on entry to GAP; aborted frames never reach GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'd0;
        end else if ((next_s == GAP) && (state_r != GAP)) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: randomized command stream against a slave RAM model and a command-level reference.
// With SPI_RAM_MASTER_STATUS_EN defined the bench runs at CLK_DIV=1 and also checks frame_cnt.
module tb_spi_ram_master;

`ifdef SPI_RAM_MASTER_STATUS_EN
    localparam int CLK_DIV = 1;
`else
    localparam int CLK_DIV = 2;
`endif
    localparam int WR_LOW = 21 * CLK_DIV;
    localparam int RD_LOW = 39 * CLK_DIV;
    localparam int TMO    = 400;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;
`ifdef SPI_RAM_MASTER_STATUS_EN
    logic [15:0] frame_cnt;
`endif

    spi_ram_master #(.CLK_DIV(CLK_DIV), .ADDR_SIZE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sclk      (sclk),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
`ifdef SPI_RAM_MASTER_STATUS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave RAM on the wire: decodes frames from mosi and answers RD_DATA on miso.
    logic [9:0] frames[$];
    initial begin
        logic [7:0] mem[256];
        logic [7:0] wa, ra, rbyte;
        logic [9:0] sh;
        int         cnt;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        wa = 8'h00; ra = 8'h00; rbyte = 8'h00; sh = 10'h000; cnt = 0;
        forever begin
            @(posedge sclk or negedge sclk or posedge ss_n);
            if (ss_n === 1'b1) begin
                cnt  = 0;
                miso = 1'b0;
            end else if (sclk === 1'b1) begin
                cnt++;
                if (cnt <= 10) sh = {sh[8:0], mosi};
                if (cnt == 10) begin
                    frames.push_back(sh);
                    case (sh[9:8])
                        2'b00:   wa = sh[7:0];
                        2'b01:   mem[wa] = sh[7:0];
                        2'b10:   ra = sh[7:0];
                        default: rbyte = mem[ra];
                    endcase
                end
            end else begin
                if (cnt >= 11 && cnt <= 18 && sh[9:8] == 2'b11) miso = rbyte[18 - cnt];
                else miso = 1'b0;
            end
        end
    end

    // Protocol monitor: ss_n low/high run lengths, response timing, sclk/mosi discipline.
    int         lows[$];
    int         gaps[$];
    logic [7:0] rsps[$];
    int   low_cnt = 0, high_cnt = 0;
    int   bad_rsp = 0, bad_sclk = 0, bad_mosi = 0;
    logic prev_ss_n = 1'b1, prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ss_n <= 1'b1;
            low_cnt   <= 0;
            high_cnt  <= 0;
        end else begin
            if (!ss_n) begin
                if (prev_ss_n) begin
                    gaps.push_back(high_cnt);
                    low_cnt <= 1;
                end else begin
                    low_cnt <= low_cnt + 1;
                end
            end else begin
                if (!prev_ss_n) begin
                    lows.push_back(low_cnt);
                    high_cnt <= 1;
                end else begin
                    high_cnt <= high_cnt + 1;
                end
            end
            if (rsp_valid) begin
                rsps.push_back(rsp_data);
                if (!(ss_n && !prev_ss_n)) bad_rsp <= bad_rsp + 1;
            end
            if (ss_n && sclk) bad_sclk <= bad_sclk + 1;
            if (sclk && (mosi !== prev_mosi)) bad_mosi <= bad_mosi + 1;
            prev_ss_n <= ss_n;
            prev_mosi <= mosi;
        end
    end

    // Command-level reference: RAM write/read address registers and contents.
    logic [7:0] ref_mem[256];
    logic [7:0] ref_wa = 8'h00, ref_ra = 8'h00;
    int         exp_fc = 0;

    task automatic send(input logic [9:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && t < TMO) begin @(negedge clk); t++; end
        check_eq("accept_timeout", 32'(t < TMO), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 10'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < TMO) begin @(negedge clk); t++; end
        check_eq("idle_timeout", 32'(t < TMO), 32'd1);
        @(negedge clk);
    endtask

    task automatic ref_apply(input logic [9:0] d, output logic [7:0] exp_rd);
        exp_rd = 8'h00;
        case (d[9:8])
            2'b00:   ref_wa = d[7:0];
            2'b01:   ref_mem[ref_wa] = d[7:0];
            2'b10:   ref_ra = d[7:0];
            default: exp_rd = ref_mem[ref_ra];
        endcase
        exp_fc++;
    endtask

    task automatic run_cmd(input logic [9:0] d, input bit glitch);
        int nf = frames.size();
        int nr = rsps.size();
        logic [7:0] exp_rd;
        bit is_rd = (d[9:8] == 2'b11);
        send(d);
        if (glitch) begin
            repeat ($urandom_range(2, 20 * CLK_DIV - 1)) @(negedge clk);
            cmd_valid = 1'b1;
            cmd_data  = 10'h3FF;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        wait_idle();
        ref_apply(d, exp_rd);
        check_eq("frame_count", 32'(frames.size()), 32'(nf + 1));
        if (frames.size() > nf) check_eq("frame_bits", 32'(frames[$]), 32'(d));
        if (lows.size() > 0) check_eq("ss_low_len", 32'(lows[$]), is_rd ? 32'(RD_LOW) : 32'(WR_LOW));
        check_eq("rsp_count", 32'(rsps.size()), 32'(nr + (is_rd ? 1 : 0)));
        if (is_rd && rsps.size() > nr) check_eq("rsp_data", 32'(rsps[$]), 32'(exp_rd));
    endtask

    initial begin
        logic [9:0] seq[4];
        logic [7:0] exp_rd;
        int ng, nf, nr, rises, t;
        logic s_prev;
        logic [1:0] op;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'hA5;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 10'h000;
        repeat (3) @(negedge clk);
        check_eq("rst_ss_n", 32'(ss_n), 32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
`ifdef SPI_RAM_MASTER_STATUS_EN
        check_eq("frame_cnt_rst", 32'(frame_cnt), 32'd0);
`endif

        run_cmd(10'h028, 1'b0);
        run_cmd(10'h300, 1'b0);
`ifdef SPI_RAM_MASTER_STATUS_EN
        run_cmd(10'h1C3, 1'b0);
        check_eq("frame_cnt_three", 32'(frame_cnt), 32'd3);
`endif

        // Back-to-back with cmd_valid held high.
        seq[0] = 10'h028; seq[1] = 10'h118; seq[2] = 10'h228; seq[3] = 10'h300;
        ng = gaps.size(); nf = frames.size(); nr = rsps.size();
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_data = seq[i];
            t = 0;
            while (!cmd_ready && t < TMO) begin @(negedge clk); t++; end
            check_eq("b2b_accept_timeout", 32'(t < TMO), 32'd1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) ref_apply(seq[i], exp_rd);
        check_eq("b2b_frames", 32'(frames.size()), 32'(nf + 4));
        check_eq("b2b_gap_count", 32'(gaps.size()), 32'(ng + 4));
        if (gaps.size() == ng + 4) begin
            for (int i = 1; i < 4; i++) check_eq("b2b_gap_len", 32'(gaps[ng + i]), 32'(2 * CLK_DIV));
        end
        if (frames.size() == nf + 4) begin
            for (int i = 0; i < 4; i++) check_eq("b2b_frame_bits", 32'(frames[nf + i]), 32'(seq[i]));
        end
        check_eq("b2b_rsp_count", 32'(rsps.size()), 32'(nr + 1));
        if (rsps.size() > nr) check_eq("b2b_rsp_data", 32'(rsps[$]), 32'h18);

        // Randomized command stream, occasionally with a 0x3FF pulse during the frame.
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            run_cmd({op, (op == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 7))}, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a RD_DATA frame.
        nf = frames.size(); nr = rsps.size();
        send(10'h300);
        rises = 0; t = 0; s_prev = sclk;
        while (rises < 5 && t < TMO) begin
            @(negedge clk);
            if (sclk && !s_prev) rises++;
            s_prev = sclk;
            t++;
        end
        check_eq("abort_rise_wait", 32'(rises), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_ss_n", 32'(ss_n), 32'd1);
        check_eq("abort_sclk", 32'(sclk), 32'd0);
        check_eq("abort_mosi", 32'(mosi), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 0;
        ref_ra = ref_ra;
        repeat (5) @(negedge clk);
        check_eq("abort_no_rsp", 32'(rsps.size()), 32'(nr));
        check_eq("abort_no_frame", 32'(frames.size()), 32'(nf));
`ifdef SPI_RAM_MASTER_STATUS_EN
        check_eq("frame_cnt_after_rst", 32'(frame_cnt), 32'd0);
`endif
        run_cmd(10'h003, 1'b0);
        run_cmd(10'h15C, 1'b0);
        run_cmd(10'h203, 1'b0);
        run_cmd(10'h300, 1'b0);
`ifdef SPI_RAM_MASTER_STATUS_EN
        check_eq("frame_cnt_final", 32'(frame_cnt), 32'(exp_fc));
`endif

        check_eq("rsp_with_ss_rise", 32'(bad_rsp), 32'd0);
        check_eq("sclk_while_deselected", 32'(bad_sclk), 32'd0);
        check_eq("mosi_while_sclk_high", 32'(bad_mosi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
